vram_xor: RTL and testbench

//   Parametrised successor to the CHIP-8 frame store. Dual-port pixel RAM:

---
 rtl/vram_xor_if.sv | 33 +++
 rtl/vram_xor.sv | 99 +++++++++
 tb/tb_vram_xor.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vram_xor_if.sv
// CPU-side and scanout-side signal bundle for the vram_xor pixel store.
// The master drives addresses, data and requests; the slave is the RAM block.
interface vram_xor_if #(
   parameter int HBITS = 7,
   parameter int VBITS = 6,
   parameter int PBITS = 2
);
   logic [HBITS-1:0] hpos;
   logic [VBITS-1:0] vpos;
   logic [PBITS-1:0] pixeli;
   logic             we;
   logic             xor_mode;
   logic             clear_req;
   logic             collision_clr;
   logic [PBITS-1:0] pixelo;
   logic             busy;
   logic             collision;
   logic [HBITS-1:0] vdrive_hpos;
   logic [VBITS-1:0] vdrive_vpos;
   logic [PBITS-1:0] vdrive_pixel;

   modport master (
      output hpos, vpos, pixeli, we, xor_mode, clear_req, collision_clr,
      output vdrive_hpos, vdrive_vpos,
      input  pixelo, busy, collision, vdrive_pixel
   );

   modport slave (
      input  hpos, vpos, pixeli, we, xor_mode, clear_req, collision_clr,
      input  vdrive_hpos, vdrive_vpos,
      output pixelo, busy, collision, vdrive_pixel
   );
endinterface

// File: rtl/vram_xor.sv
// Dual-port pixel frame store: CPU port with replace/XOR-draw, sticky collision
// and a whole-frame clear engine; read-only scanout port for the video driver.
module vram_xor #(
   parameter int               HBITS       = 7,
   parameter int               VBITS       = 6,
   parameter int               PBITS       = 2,
   parameter logic [PBITS-1:0] CLEAR_VALUE = '0
) (
   input logic       clk,
   input logic       reset,
   vram_xor_if.slave bus
);
   localparam int AW    = HBITS + VBITS;
   localparam int DEPTH = 2 ** AW;

   typedef enum logic [1:0] {IDLE, XOR_WB, CLEAR} state_t;

   state_t           state, state_nx;
   logic [PBITS-1:0] mem [DEPTH];
   logic [AW-1:0]    cpu_addr, addr_a, lat_addr, clr_cnt;
   logic [PBITS-1:0] lat_pix, wr_data, pixelo_q, vdrive_q;
   logic             wr_en, col_set, collision_q;

   assign cpu_addr = {bus.vpos, bus.hpos};

   // Port A has a single address shared by its read and write; the FSM picks
   // whether it points at the CPU, the latched XOR target or the clear counter.
   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      addr_a   = cpu_addr;
      wr_data  = bus.pixeli;
      col_set  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.clear_req) begin
               state_nx = CLEAR;
            end else if (bus.we) begin
               if (bus.xor_mode) state_nx = XOR_WB;
               else              wr_en    = 1'b1;
            end
         end
         XOR_WB: begin
            addr_a   = lat_addr;
            wr_en    = 1'b1;
            wr_data  = pixelo_q ^ lat_pix;
            col_set  = |(pixelo_q & lat_pix);
            state_nx = IDLE;
         end
         CLEAR: begin
            addr_a  = clr_cnt;
            wr_en   = 1'b1;
            wr_data = CLEAR_VALUE;
            if (clr_cnt == '1) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Contents survive reset; only the write in the reset cycle is suppressed.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[addr_a] <= wr_data;
   end

   // The old word read in IDLE doubles as the XOR operand in XOR_WB.
   always_ff @(posedge clk) begin
      if (reset) begin
         pixelo_q <= '0;
         vdrive_q <= '0;
      end else begin
         if (state == IDLE) pixelo_q <= mem[addr_a];
         vdrive_q <= mem[{bus.vdrive_vpos, bus.vdrive_hpos}];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         clr_cnt     <= '0;
         collision_q <= 1'b0;
         lat_addr    <= '0;
         lat_pix     <= '0;
      end else begin
         state <= state_nx;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
         if (state == IDLE) begin
            lat_addr <= cpu_addr;
            lat_pix  <= bus.pixeli;
         end
         if (col_set)                collision_q <= 1'b1;
         else if (bus.collision_clr) collision_q <= 1'b0;
      end
   end

   assign bus.pixelo       = pixelo_q;
   assign bus.vdrive_pixel = vdrive_q;
   assign bus.busy         = (state != IDLE);
   assign bus.collision    = collision_q;
endmodule

// File: tb/tb_vram_xor.sv
// Directed bench for vram_xor: table of CPU/scanout operations on a cleared
// frame plus hand sequences for clear timing, collision priority and reset abort.
module tb_vram_xor;
   typedef enum logic [1:0] {OP_WR, OP_RD, OP_XR, OP_SC} op_t;

   typedef struct {
      op_t        op;
      logic [6:0] h;
      logic [5:0] v;
      logic [1:0] d;
      logic [1:0] exp_pix;
      logic       exp_col;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs [15];

   always #5 clk = ~clk;

   vram_xor_if #(.HBITS(7), .VBITS(6), .PBITS(2)) bus ();

   vram_xor dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One table record: drive it for as many cycles as the operation needs.
   task automatic apply_stimulus(input int idx, input vec_t t);
      case (t.op)
         OP_WR: begin
            bus.hpos = t.h; bus.vpos = t.v; bus.pixeli = t.d;
            bus.we = 1'b1; bus.xor_mode = 1'b0;
            tick();
            bus.we = 1'b0;
            check_output($sformatf("v%0d_wr_old", idx), 32'(bus.pixelo), 32'(t.exp_pix));
            check_output($sformatf("v%0d_wr_busy", idx), 32'(bus.busy), 32'd0);
         end
         OP_RD: begin
            bus.hpos = t.h; bus.vpos = t.v; bus.we = 1'b0;
            tick();
            check_output($sformatf("v%0d_rd", idx), 32'(bus.pixelo), 32'(t.exp_pix));
         end
         OP_XR: begin
            bus.hpos = t.h; bus.vpos = t.v; bus.pixeli = t.d;
            bus.we = 1'b1; bus.xor_mode = 1'b1;
            tick();
            bus.we = 1'b0; bus.xor_mode = 1'b0;
            check_output($sformatf("v%0d_xor_busy1", idx), 32'(bus.busy), 32'd1);
            tick();
            check_output($sformatf("v%0d_xor_busy0", idx), 32'(bus.busy), 32'd0);
            check_output($sformatf("v%0d_xor_col", idx), 32'(bus.collision), 32'(t.exp_col));
         end
         default: begin
            bus.vdrive_hpos = t.h; bus.vdrive_vpos = t.v;
            tick();
            check_output($sformatf("v%0d_scan", idx), 32'(bus.vdrive_pixel), 32'(t.exp_pix));
         end
      endcase
   endtask

   task automatic read_px(input string name, input logic [6:0] h, input logic [5:0] v,
                          input logic [1:0] exp);
      bus.hpos = h; bus.vpos = v; bus.we = 1'b0;
      tick();
      check_output(name, 32'(bus.pixelo), 32'(exp));
   endtask

   initial begin
      int n;

      // Expected contents assume the frame has just been cleared to zero.
      vecs[0]  = '{OP_WR, 7'd5,   6'd3,  2'b10, 2'b00, 1'b0};
      vecs[1]  = '{OP_RD, 7'd5,   6'd3,  2'b00, 2'b10, 1'b0};
      vecs[2]  = '{OP_SC, 7'd5,   6'd3,  2'b00, 2'b10, 1'b0};
      vecs[3]  = '{OP_XR, 7'd0,   6'd0,  2'b01, 2'b00, 1'b0};
      vecs[4]  = '{OP_RD, 7'd0,   6'd0,  2'b00, 2'b01, 1'b0};
      vecs[5]  = '{OP_SC, 7'd0,   6'd0,  2'b00, 2'b01, 1'b0};
      vecs[6]  = '{OP_XR, 7'd0,   6'd0,  2'b01, 2'b00, 1'b1};
      vecs[7]  = '{OP_RD, 7'd0,   6'd0,  2'b00, 2'b00, 1'b0};
      vecs[8]  = '{OP_XR, 7'd10,  6'd20, 2'b11, 2'b00, 1'b1};
      vecs[9]  = '{OP_RD, 7'd10,  6'd20, 2'b00, 2'b11, 1'b0};
      vecs[10] = '{OP_XR, 7'd10,  6'd20, 2'b01, 2'b00, 1'b1};
      vecs[11] = '{OP_RD, 7'd10,  6'd20, 2'b00, 2'b10, 1'b0};
      vecs[12] = '{OP_WR, 7'd127, 6'd63, 2'b01, 2'b00, 1'b0};
      vecs[13] = '{OP_SC, 7'd127, 6'd63, 2'b00, 2'b01, 1'b0};
      vecs[14] = '{OP_RD, 7'd127, 6'd0,  2'b00, 2'b00, 1'b0};

      bus.hpos = '0; bus.vpos = '0; bus.pixeli = '0; bus.we = 1'b0;
      bus.xor_mode = 1'b0; bus.clear_req = 1'b0; bus.collision_clr = 1'b0;
      bus.vdrive_hpos = '0; bus.vdrive_vpos = '0;
      reset = 1'b1;
      tick();
      tick();
      check_output("rst_pixelo", 32'(bus.pixelo), 32'd0);
      check_output("rst_vdrive", 32'(bus.vdrive_pixel), 32'd0);
      check_output("rst_busy", 32'(bus.busy), 32'd0);
      check_output("rst_collision", 32'(bus.collision), 32'd0);
      reset = 1'b0;
      tick();

      // Full clear with write requests hammering the port while busy.
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < 9000) begin
         bus.we       = (n < 8000);
         bus.xor_mode = n[0];
         bus.hpos     = 7'(n);
         bus.vpos     = 6'(n >> 7);
         bus.pixeli   = 2'b11;
         n++;
         tick();
      end
      bus.we = 1'b0; bus.xor_mode = 1'b0;
      check_output("clear_busy_cycles", 32'(n), 32'd8192);
      check_output("clear_collision", 32'(bus.collision), 32'd0);
      read_px("clear_rd_0_0", 7'd0, 6'd0, 2'b00);
      read_px("clear_rd_127_63", 7'd127, 6'd63, 2'b00);
      read_px("clear_rd_64_32", 7'd64, 6'd32, 2'b00);

      for (int i = 0; i < 15; i++) apply_stimulus(i, vecs[i]);

      // Scanout and CPU write hit the same word in one cycle: both see old data.
      bus.vdrive_hpos = 7'd5; bus.vdrive_vpos = 6'd3;
      bus.hpos = 7'd5; bus.vpos = 6'd3; bus.pixeli = 2'b01; bus.we = 1'b1;
      tick();
      bus.we = 1'b0;
      check_output("same_addr_scan_old", 32'(bus.vdrive_pixel), 32'd2);
      check_output("same_addr_cpu_old", 32'(bus.pixelo), 32'd2);
      tick();
      check_output("same_addr_scan_new", 32'(bus.vdrive_pixel), 32'd1);

      bus.collision_clr = 1'b1;
      tick();
      bus.collision_clr = 1'b0;
      check_output("col_clr", 32'(bus.collision), 32'd0);
      apply_stimulus(20, '{OP_XR, 7'd20, 6'd10, 2'b01, 2'b00, 1'b0});

      // Collision set during XOR_WB coincides with a clear pulse: set wins.
      bus.hpos = 7'd10; bus.vpos = 6'd20; bus.pixeli = 2'b10;
      bus.we = 1'b1; bus.xor_mode = 1'b1;
      tick();
      bus.we = 1'b0; bus.xor_mode = 1'b0; bus.collision_clr = 1'b1;
      tick();
      bus.collision_clr = 1'b0;
      check_output("col_set_beats_clr", 32'(bus.collision), 32'd1);
      read_px("col_set_word", 7'd10, 6'd20, 2'b00);

      apply_stimulus(21, '{OP_WR, 7'd50, 6'd0,  2'b11, 2'b00, 1'b0});
      apply_stimulus(22, '{OP_WR, 7'd8,  6'd39, 2'b10, 2'b00, 1'b0});

      // clear_req beats a simultaneous write; reset at clear cycle 100 aborts.
      bus.hpos = 7'd127; bus.vpos = 6'd63; bus.pixeli = 2'b11;
      bus.we = 1'b1; bus.clear_req = 1'b1;
      tick();
      bus.we = 1'b0; bus.clear_req = 1'b0;
      check_output("abort_busy_start", 32'(bus.busy), 32'd1);
      repeat (99) tick();
      check_output("abort_busy_c100", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_output("abort_busy_after_rst", 32'(bus.busy), 32'd0);
      check_output("abort_col_after_rst", 32'(bus.collision), 32'd0);
      check_output("abort_pixelo_after_rst", 32'(bus.pixelo), 32'd0);
      read_px("abort_addr50", 7'd50, 6'd0, 2'b00);
      read_px("abort_addr5000", 7'd8, 6'd39, 2'b10);
      read_px("abort_write_dropped", 7'd127, 6'd63, 2'b01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
